// File: rtl/xif_result_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : xif_result_arbiter_pkg                                    |
// | Brief    : CV-X-IF result layout and width helpers for the result    |
// |            arbiter.                                                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package xif_result_arbiter_pkg;

   // Default interface geometry; the arbiter itself is sized by parameters.
   localparam int DEF_HARTID_W = 1;
   localparam int DEF_ID_W     = 4;
   localparam int DEF_RFW_W    = 32;
   localparam int DEF_DUALWR   = 0;

   // Result record, most significant field first (hartid at the top, err at bit 0).
   typedef struct packed {
      logic [DEF_HARTID_W-1:0] hartid;
      logic [DEF_ID_W-1:0]     id;
      logic [DEF_RFW_W-1:0]    data;
      logic [4:0]              rd;
      logic [DEF_DUALWR:0]     we;
      logic [2:0]              ecswe;
      logic [5:0]              ecsdata;
      logic                    exc;
      logic [5:0]              exccode;
      logic                    dbg;
      logic                    err;
   } x_result_t;

   // Packed width of a result for an arbitrary interface geometry.
   function automatic int result_width(input int hartid_w, input int id_w,
                                       input int rfw_w, input int dualwrite);
      return hartid_w + id_w + rfw_w + 5 + (dualwrite + 1) + 3 + 6 + 1 + 6 + 1 + 1;
   endfunction

   // Grant index width; never narrower than one bit.
   function automatic int grant_width(input int num_req);
      return (num_req < 2) ? 1 : $clog2(num_req);
   endfunction

endpackage
`default_nettype wire

// File: rtl/xif_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : xif_rr_picker                                             |
// | Brief    : Combinational round-robin first-one search starting at    |
// |            ptr and wrapping modulo NUM_REQ.                          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module xif_rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   grant,
   output logic               found
);

   // ptr is always below NUM_REQ, so one conditional subtract wraps the sum.
   function automatic int wrap_idx(input int base, input int off);
      int s;
      s = base + off;
      return (s >= NUM_REQ) ? s - NUM_REQ : s;
   endfunction

   // First valid requester at or after ptr wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && valid[wrap_idx(int'(ptr), i)]) begin
            found = 1'b1;
            grant = IDX_W'(wrap_idx(int'(ptr), i));
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/xif_result_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : xif_result_arbiter                                        |
// | Brief    : Merges NUM_COP CV-X-IF coprocessor result channels onto   |
// |            one CPU result channel. Round-robin with a grant lock     |
// |            that keeps a stalled result stable; flags requesters that |
// |            drop valid before the handshake.                          |
// | Options  : XIF_RESULT_ARB_OUT_REG_EN - 2-entry skid buffer on the    |
// |            core side (1-cycle latency, ready decoupled from core).   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module xif_result_arbiter
   import xif_result_arbiter_pkg::*;
#(
   parameter  int NUM_COP        = 2,
   parameter  int X_ID_WIDTH     = 4,
   parameter  int X_HARTID_WIDTH = 1,
   parameter  int X_RFW_WIDTH    = 32,
   parameter  int X_DUALWRITE    = 0,
   localparam int RESULT_W       = result_width(X_HARTID_WIDTH, X_ID_WIDTH,
                                                X_RFW_WIDTH, X_DUALWRITE),
   localparam int GIDX_W         = grant_width(NUM_COP)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [NUM_COP-1:0]                cop_result_valid_i,
   output logic [NUM_COP-1:0]                cop_result_ready_o,
   input  logic [NUM_COP-1:0][RESULT_W-1:0]  cop_result_i,
   output logic                              core_result_valid_o,
   input  logic                              core_result_ready_i,
   output logic [RESULT_W-1:0]               core_result_o,
   output logic [GIDX_W-1:0]                 grant_idx_o,
   output logic                              proto_err_o
);

   logic [GIDX_W-1:0] rr_ptr_q;
   logic [GIDX_W-1:0] lock_idx_q;
   logic [GIDX_W-1:0] last_grant_q;
   logic              lock_q;

   logic [GIDX_W-1:0] pick_grant;
   logic              pick_found;
   logic [GIDX_W-1:0] grant;
   logic [GIDX_W-1:0] next_ptr;
   logic              arb_valid;
   logic              arb_ready;
   logic              arb_xfer;
   logic              lock_drop;

   xif_rr_picker #(
      .NUM_REQ (NUM_COP),
      .IDX_W   (GIDX_W)
   ) u_picker (
      .valid (cop_result_valid_i),
      .ptr   (rr_ptr_q),
      .grant (pick_grant),
      .found (pick_found)
   );

   // While locked the held requester owns the output regardless of others;
   // reset masks the arbiter so nothing is offered while rst_ni is low.
   assign grant     = lock_q ? lock_idx_q : pick_grant;
   assign arb_valid = rst_ni & (lock_q ? cop_result_valid_i[lock_idx_q] : pick_found);
   assign lock_drop = lock_q & ~cop_result_valid_i[lock_idx_q];
   assign arb_xfer  = arb_valid & arb_ready;
   assign next_ptr  = (grant == GIDX_W'(NUM_COP - 1)) ? '0 : grant + 1'b1;

   // Error is flagged in the same cycle valid disappears; the lock clears at
   // the following edge, so the pulse is exactly one cycle long.
   assign proto_err_o = lock_drop;

   // Reported index tracks the live grant and otherwise holds the last one.
   assign grant_idx_o = arb_valid ? grant : last_grant_q;

   for (genvar k = 0; k < NUM_COP; k++) begin : g_ready
      assign cop_result_ready_o[k] = arb_valid & arb_ready & (grant == GIDX_W'(k));
   end

   // Round-robin pointer, grant lock and last-grant bookkeeping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q     <= '0;
         lock_q       <= 1'b0;
         lock_idx_q   <= '0;
         last_grant_q <= '0;
      end else begin
         if (arb_valid) begin
            last_grant_q <= grant;
         end
         if (arb_xfer) begin
            rr_ptr_q <= next_ptr;
            lock_q   <= 1'b0;
         end else if (arb_valid) begin
            lock_q     <= 1'b1;
            lock_idx_q <= grant;
         end else if (lock_drop) begin
            lock_q <= 1'b0;
         end
      end
   end

`ifdef XIF_RESULT_ARB_OUT_REG_EN
   logic [1:0]          fill_q;
   logic [RESULT_W-1:0] head_q;
   logic [RESULT_W-1:0] tail_q;
   logic                push;
   logic                pop;
   logic [RESULT_W-1:0] arb_data;

   // The arbiter sees only buffer space, never the core's ready.
   assign arb_ready           = (fill_q != 2'd2);
   assign arb_data            = cop_result_i[grant];
   assign push                = arb_xfer;
   assign pop                 = (fill_q != 2'd0) & core_result_ready_i;
   assign core_result_valid_o = (fill_q != 2'd0);
   assign core_result_o       = head_q;

   // Two-entry FIFO: head_q drives the core, tail_q catches the skid entry.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fill_q <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (fill_q == 2'd0) begin
                  head_q <= arb_data;
               end else begin
                  tail_q <= arb_data;
               end
               fill_q <= fill_q + 2'd1;
            end
            2'b01: begin
               head_q <= tail_q;
               fill_q <= fill_q - 2'd1;
            end
            2'b11: begin
               if (fill_q == 2'd1) begin
                  head_q <= arb_data;
               end else begin
                  head_q <= tail_q;
                  tail_q <= arb_data;
               end
            end
            default: begin
            end
         endcase
      end
   end
`else
   assign arb_ready           = core_result_ready_i;
   assign core_result_valid_o = arb_valid;
   assign core_result_o       = cop_result_i[grant];
`endif

endmodule
`default_nettype wire

// File: tb/tb_xif_result_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_xif_result_arbiter                                     |
// | Brief    : Directed vector bench for xif_result_arbiter, NUM_COP=4.  |
// |            Honours XIF_RESULT_ARB_OUT_REG_EN for the skid sequence.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_xif_result_arbiter;
   import xif_result_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int RW = result_width(1, 4, 32, 0);

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic [N-1:0]            valid;
   logic [N-1:0]            rdy;
   logic [N-1:0][RW-1:0]    res_in;
   logic                    core_valid;
   logic                    core_ready;
   logic [RW-1:0]           res_out;
   logic [1:0]              gidx;
   logic                    err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   xif_result_arbiter #(
      .NUM_COP        (N),
      .X_ID_WIDTH     (4),
      .X_HARTID_WIDTH (1),
      .X_RFW_WIDTH    (32),
      .X_DUALWRITE    (0)
   ) dut (
      .clk_i               (clk),
      .rst_ni              (rst_n),
      .cop_result_valid_i  (valid),
      .cop_result_ready_o  (rdy),
      .cop_result_i        (res_in),
      .core_result_valid_o (core_valid),
      .core_result_ready_i (core_ready),
      .core_result_o       (res_out),
      .grant_idx_o         (gidx),
      .proto_err_o         (err)
   );

   // Result carrying the id and a per-coprocessor tag in several fields.
   function automatic logic [RW-1:0] mk(input logic [3:0] id, input int cop);
      x_result_t r;
      r        = '0;
      r.hartid = 1'(cop);
      r.id     = id;
      r.data   = {16'hC0DE, 8'(cop), 4'h0, id};
      r.rd     = 5'(cop + 1);
      r.we     = 1'b1;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic r, input logic [15:0] ids);
      valid      = v;
      core_ready = r;
      for (int k = 0; k < N; k++) res_in[k] = mk(ids[k*4 +: 4], k);
   endtask

   typedef struct {
      logic [3:0]  v;
      logic        r;
      logic [15:0] ids;   // {id3,id2,id1,id0}
      logic        e_valid;
      logic [1:0]  e_grant;
      logic [3:0]  e_rdy;
      logic        e_err;
   } vec_t;

   function automatic vec_t mkv(input logic [3:0] v, input logic r, input logic [15:0] ids,
                                input logic ev, input logic [1:0] eg, input logic [3:0] er,
                                input logic ee);
      vec_t t;
      t.v = v; t.r = r; t.ids = ids; t.e_valid = ev; t.e_grant = eg; t.e_rdy = er; t.e_err = ee;
      return t;
   endfunction

   vec_t tbl[19];

   initial begin
      // alternation between cop0/cop1
      tbl[0]  = mkv(4'b0000, 1'b1, 16'h0000, 1'b0, 2'd0, 4'b0000, 1'b0);
      tbl[1]  = mkv(4'b0011, 1'b1, 16'h0021, 1'b1, 2'd0, 4'b0001, 1'b0);
      tbl[2]  = mkv(4'b0011, 1'b1, 16'h0021, 1'b1, 2'd1, 4'b0010, 1'b0);
      tbl[3]  = mkv(4'b0011, 1'b1, 16'h0021, 1'b1, 2'd0, 4'b0001, 1'b0);
      tbl[4]  = mkv(4'b0011, 1'b1, 16'h0021, 1'b1, 2'd1, 4'b0010, 1'b0);
      // cop0 id3 stalls three cycles while cop1 id5 waits
      tbl[5]  = mkv(4'b0001, 1'b0, 16'h0053, 1'b1, 2'd0, 4'b0000, 1'b0);
      tbl[6]  = mkv(4'b0011, 1'b0, 16'h0053, 1'b1, 2'd0, 4'b0000, 1'b0);
      tbl[7]  = mkv(4'b0011, 1'b0, 16'h0053, 1'b1, 2'd0, 4'b0000, 1'b0);
      tbl[8]  = mkv(4'b0011, 1'b1, 16'h0053, 1'b1, 2'd0, 4'b0001, 1'b0);
      tbl[9]  = mkv(4'b0010, 1'b1, 16'h0053, 1'b1, 2'd1, 4'b0010, 1'b0);
      // cop3 locked then drops valid; pointer stays at 2
      tbl[10] = mkv(4'b1000, 1'b0, 16'h7000, 1'b1, 2'd3, 4'b0000, 1'b0);
      tbl[11] = mkv(4'b1001, 1'b0, 16'h7008, 1'b1, 2'd3, 4'b0000, 1'b0);
      tbl[12] = mkv(4'b0101, 1'b0, 16'h7908, 1'b0, 2'd3, 4'b0000, 1'b1);
      tbl[13] = mkv(4'b0101, 1'b1, 16'h7908, 1'b1, 2'd2, 4'b0100, 1'b0);
      tbl[14] = mkv(4'b0001, 1'b1, 16'h0008, 1'b1, 2'd0, 4'b0001, 1'b0);
      // cop3 wraps the pointer to 0, then loses priority to cop0
      tbl[15] = mkv(4'b1000, 1'b1, 16'hA000, 1'b1, 2'd3, 4'b1000, 1'b0);
      tbl[16] = mkv(4'b1001, 1'b1, 16'hC00B, 1'b1, 2'd0, 4'b0001, 1'b0);
      tbl[17] = mkv(4'b1000, 1'b1, 16'hC000, 1'b1, 2'd3, 4'b1000, 1'b0);
      tbl[18] = mkv(4'b0000, 1'b1, 16'h0000, 1'b0, 2'd3, 4'b0000, 1'b0);

      // reset with every requester asserting valid
      drive(4'b1111, 1'b1, 16'h4321);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2;
      check("reset valid", 64'(core_valid), 64'd0);
      check("reset ready", 64'(rdy), 64'd0);
      check("reset grant", 64'(gidx), 64'd0);
      check("reset err", 64'(err), 64'd0);
`ifdef XIF_RESULT_ARB_OUT_REG_EN
      check("reset data", 64'(res_out), 64'd0);
`endif
      @(negedge clk);
      drive(4'b0000, 1'b1, 16'h0000);
      rst_n = 1'b1;

`ifndef XIF_RESULT_ARB_OUT_REG_EN
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         drive(tbl[i].v, tbl[i].r, tbl[i].ids);
         #2;
         check($sformatf("v%0d valid", i), 64'(core_valid), 64'(tbl[i].e_valid));
         check($sformatf("v%0d grant", i), 64'(gidx), 64'(tbl[i].e_grant));
         check($sformatf("v%0d ready", i), 64'(rdy), 64'(tbl[i].e_rdy));
         check($sformatf("v%0d err", i), 64'(err), 64'(tbl[i].e_err));
         if (tbl[i].e_valid)
            check($sformatf("v%0d data", i), 64'(res_out),
                  64'(mk(tbl[i].ids[tbl[i].e_grant*4 +: 4], int'(tbl[i].e_grant))));
      end

      // reset while cop2 is locked
      @(negedge clk);
      drive(4'b0100, 1'b0, 16'h0400);
      #2;
      check("lock2 grant", 64'(gidx), 64'd2);
      @(negedge clk);
      drive(4'b0101, 1'b0, 16'h0401);
      #2;
      check("lock2 hold", 64'(gidx), 64'd2);
      check("lock2 valid", 64'(core_valid), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst valid", 64'(core_valid), 64'd0);
      check("midrst ready", 64'(rdy), 64'd0);
      check("midrst grant", 64'(gidx), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b0101, 1'b1, 16'h0401);
      #2;
      check("postrst grant", 64'(gidx), 64'd0);
      check("postrst ready", 64'(rdy), 64'b0001);
      check("postrst data", 64'(res_out), 64'(mk(4'd1, 0)));
      @(negedge clk);
      #2;
      check("postrst next", 64'(gidx), 64'd2);
      check("postrst data2", 64'(res_out), 64'(mk(4'd4, 2)));
`else
      begin
         int sent = 0;
         int recv = 0;
         int fill = 0;
         logic pushed;
         logic popped;
         for (int c = 0; c < 60 && recv < 8; c++) begin
            @(negedge clk);
            if (sent < 8) drive(4'b0001, (c % 2) == 0, 16'(sent));
            else          drive(4'b0000, (c % 2) == 0, 16'h0000);
            #2;
            check($sformatf("skid c%0d valid", c), 64'(core_valid), 64'(fill > 0));
            if (sent < 8)
               check($sformatf("skid c%0d ready", c), 64'(rdy[0]), 64'(fill < 2));
            check($sformatf("skid c%0d others", c), 64'(rdy[3:1]), 64'd0);
            pushed = rdy[0] & valid[0];
            popped = core_valid & core_ready;
            if (popped) begin
               check($sformatf("skid out%0d", recv), 64'(res_out), 64'(mk(4'(recv), 0)));
               recv++;
            end
            if (pushed) sent++;
            fill = fill + int'(pushed) - int'(popped);
         end
         check("skid delivered", 64'(recv), 64'd8);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
